// File: rtl/conv_out_packer_if.sv
// Result-byte input stream and 32-bit AXI-Stream output of the conv output packer.
// The packer takes the master side; the producer and the DMA sink take the slave side.
interface conv_out_packer_if;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TUSER;

  modport master (
    input  res_valid, res_data, M_AXIS_TREADY,
    output res_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER
  );

  modport slave (
    output res_valid, res_data, M_AXIS_TREADY,
    input  res_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER
  );
endinterface

// File: rtl/conv_out_packer.sv
// Packs conv result bytes little-endian into 32-bit AXIS words with TUSER/TLAST/TKEEP framing.
// One-cycle latency from the completing byte to TVALID; a completing byte stalls only while the output word is stuck.
module conv_out_packer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int CNT_W                  = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [8:0] OutCh,
  input  logic [5:0] FLength,
  output logic       busy,
  output logic       done,
  conv_out_packer_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_PACK, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [8:0]                        out_ch_r;
  logic [5:0]                        flen_r;
  logic [CNT_W-1:0]                  total_r;
  logic [CNT_W-1:0]                  cnt_r;
  logic [CNT_W-1:0]                  total_calc;
  logic [1:0]                        lane_r;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] pack_r;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] word_nxt;
  logic [3:0]                        keep_nxt;
  logic                              first_r;

  logic                              tvalid_r;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] tdata_r;
  logic [3:0]                        tkeep_r;
  logic                              tlast_r;
  logic                              tuser_r;

  logic final_byte, completing, out_stall, rdy, accept;

  assign total_calc = CNT_W'(out_ch_r) * CNT_W'(flen_r) * CNT_W'(flen_r);
  assign final_byte = (cnt_r == total_r - CNT_W'(1));
  assign completing = (lane_r == 2'd3) || final_byte;
  assign out_stall  = tvalid_r && !bus.M_AXIS_TREADY;
  assign accept     = bus.res_valid && rdy;

  // Incoming byte merged into its lane; lanes above it are still zero in pack_r.
  always_comb begin
    word_nxt = pack_r;
    word_nxt[8*lane_r +: 8] = bus.res_data;
  end

  always_comb begin
    keep_nxt = 4'hF;
    case (lane_r)
      2'd0:    keep_nxt = 4'h1;
      2'd1:    keep_nxt = 4'h3;
      2'd2:    keep_nxt = 4'h7;
      default: keep_nxt = 4'hF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  state_nxt = (total_calc == '0) ? S_DONE : S_PACK;
      S_PACK:  if (accept && final_byte) state_nxt = S_DRAIN;
      // Only the TLAST word can be in the output register here.
      S_DRAIN: if (tvalid_r && bus.M_AXIS_TREADY) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    rdy  = (state == S_PACK) && !(bus.res_valid && completing && out_stall);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_ch_r <= '0;
      flen_r   <= '0;
      total_r  <= '0;
      cnt_r    <= '0;
      lane_r   <= '0;
      pack_r   <= '0;
      first_r  <= 1'b0;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
      tkeep_r  <= '0;
      tlast_r  <= 1'b0;
      tuser_r  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        out_ch_r <= OutCh;
        flen_r   <= FLength;
      end
      if (state == S_CALC) begin
        total_r <= total_calc;
        cnt_r   <= '0;
        lane_r  <= '0;
        pack_r  <= '0;
        first_r <= 1'b1;
      end
      if (accept) begin
        cnt_r <= cnt_r + CNT_W'(1);
        if (completing) begin
          lane_r <= '0;
          pack_r <= '0;
        end else begin
          lane_r <= lane_r + 2'd1;
          pack_r <= word_nxt;
        end
      end
      // A completing byte is only accepted when the register is empty or draining now.
      if (accept && completing) begin
        tvalid_r <= 1'b1;
        tdata_r  <= word_nxt;
        tkeep_r  <= keep_nxt;
        tlast_r  <= final_byte;
        tuser_r  <= first_r;
        first_r  <= 1'b0;
      end else if (tvalid_r && bus.M_AXIS_TREADY) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  assign bus.res_ready     = rdy;
  assign bus.M_AXIS_TVALID = tvalid_r;
  assign bus.M_AXIS_TDATA  = tdata_r;
  assign bus.M_AXIS_TKEEP  = tkeep_r;
  assign bus.M_AXIS_TLAST  = tlast_r;
  assign bus.M_AXIS_TUSER  = tuser_r;

endmodule

// File: doc/conv_out_packer.md
Name: conv_out_packer

Overview:
- Downstream stage of the convolution datapath: consumes the conv engine's 8-bit output activations one byte per handshake.
- Packs four consecutive bytes little-endian into 32-bit words and drives them onto the top-level master AXI-Stream towards DMA.
- Generates frame framing: TUSER on the first beat, TLAST and partial TKEEP on the last beat.
- Reports completion to the APB-visible control path with a one-cycle done pulse.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, stream data width; only 32 is supported.
- CNT_W, 21, element counter width; covers 511*63*63 = 2028159.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latch OutCh/FLength and begin a frame
- OutCh  in  9  number of output channels
- FLength  in  6  output feature-map side length
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last beat handshake
- res_valid  in  1  result byte valid
- res_data  in  8  result byte
- res_ready  out  1  packer accepts res_data
- M_AXIS_TREADY  in  1  sink ready
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TDATA  out  32  packed word
- M_AXIS_TKEEP  out  4  byte enables
- M_AXIS_TLAST  out  1  last beat of frame
- M_AXIS_TUSER  out  1  first beat of frame

Behaviour:
- Reset (RESET=1 at a CLK edge): state IDLE; all outputs 0 the following cycle; counters and pack register cleared. Takes effect mid-frame too; partial data is discarded.
- States and transitions:
  - IDLE -> CALC on start.
  - CALC: total = OutCh*FLength*FLength registered (CNT_W bits, no overflow possible). Go to DONE if total==0, else PACK.
  - PACK: accept bytes until total have been accepted, then DRAIN.
  - DRAIN: wait for the TLAST handshake, then DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- busy=1 in CALC, PACK, DRAIN and DONE.
- Byte lanes: the k-th accepted byte of a word goes to TDATA[8k+7:8k], lane 0 first.
- A word completes on the lane-3 byte or on the frame's final byte, whichever comes first.
- Output register is single-stage. A completed word loads into it on the cycle after the completing byte handshake, so latency is 1 cycle.
- res_ready = (state==PACK) && !(completing byte pending && M_AXIS_TVALID && !M_AXIS_TREADY).
- Throughput: 1 byte/cycle sustained while TREADY=1.
- AXIS rule: once TVALID=1, TDATA, TKEEP, TLAST and TUSER hold stable until TVALID&TREADY.
- TKEEP is 4'hF except on the last beat, where it depends on total mod 4:
  - 1 -> 4'h1
  - 2 -> 4'h3
  - 3 -> 4'h7
  - 0 -> 4'hF
- Unused lanes of a partial word are 0.
- TUSER=1 only on the first beat of a frame; a single-beat frame has TUSER=TLAST=1.
- Simultaneous output drain and new word completion in the same cycle: the register reloads without a bubble.
- done asserts the cycle after the handshake with TLAST=1.

Test Plan:
- Exact single word: OutCh=1, FLength=2, bytes 01,02,03,04, TREADY=1 -> one beat with:
  - TDATA=0x04030201, TKEEP=F, TUSER=1, TLAST=1
  - done high one cycle after that handshake; busy low the cycle after.
- Partial last word: OutCh=1, FLength=3, bytes 0x10..0x18 -> 3 beats: 0x13121110 (TUSER), 0x17161514, then 0x00000018 with TKEEP=1 and TLAST.
- Backpressure: repeat the 9-byte case with TREADY=0 for 5 cycles after the first TVALID ->
  - TDATA/TKEEP stay stable while stalled
  - res_ready drops when the second word's lane-3 byte is pending
  - output equals the no-stall case.
- Empty frame: OutCh=0, start at cycle t -> done=1 at t+2 with no TVALID; the same result for FLength=0.
- Reset mid-frame: assert RESET after 5 of 9 bytes ->
  - next cycle TVALID=0, busy=0, res_ready=0
  - a following start with 4 bytes produces the correct single beat with TUSER=1.
- Max frame and start-while-busy: OutCh=511, FLength=63, plus a second start pulse mid-frame ->
  - the second start is ignored
  - 507040 beats, with TKEEP=7 on the last beat
  - exactly one done pulse.
